jericalla_sequencer: RTL and testbench

//  Program sequencer for the Jericalla datapath (17-bit instr in, 32-bit data_out + zf back).

---
 rtl/jericalla_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_jericalla_sequencer.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/jericalla_sequencer.sv
// Program sequencer for the Jericalla datapath: buffers instructions, issues them one at a time,
// holds each for SETTLE cycles and captures data_out/zf. Optional build macro: JSEQ_ZF_HALT_EN.
module jericalla_sequencer #(
   parameter int INSTR_W = 17,
   parameter int DATA_W  = 32,
   parameter int DEPTH   = 8,
   parameter int SETTLE  = 2,
   localparam int AW     = $clog2(DEPTH)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               prog_we,
   input  logic [AW-1:0]      prog_addr,
   input  logic [INSTR_W-1:0] prog_data,
   input  logic [AW:0]        prog_len,
   input  logic               start,
   input  logic               abort,
   output logic [INSTR_W-1:0] dp_instr,
   input  logic [DATA_W-1:0]  dp_data,
   input  logic               dp_zf,
   output logic               res_valid,
   output logic [DATA_W-1:0]  res_data,
   output logic               res_zf,
   output logic [AW-1:0]      res_idx,
   output logic [AW:0]        zf_count,
   output logic               busy,
   output logic [1:0]         state_dbg,
   output logic               done
`ifdef JSEQ_ZF_HALT_EN
   ,
   output logic               halted
`endif
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam logic [AW:0] LEN_MAX   = (AW+1)'(DEPTH);
   localparam logic [3:0]  SETTLE_M1 = 4'(SETTLE - 1);

   state_t             state;
   state_t             state_nxt;
   logic [INSTR_W-1:0] mem [DEPTH];
   logic [AW-1:0]      pc;
   logic [AW:0]        len_r;
   logic [3:0]         wait_cnt;
   logic               start_ok;
   logic               capture;
   logic               last_entry;
   logic               halt_hit;
   logic               end_run;

`ifdef JSEQ_ZF_HALT_EN
   assign halt_hit = dp_zf;
`else
   assign halt_hit = 1'b0;
`endif

   assign last_entry = ({1'b0, pc} == (len_r - (AW+1)'(1)));
   assign end_run    = last_entry || halt_hit;

   assign busy      = (state == ISSUE) || (state == WAIT);
   assign done      = (state == DONE);
   assign state_dbg = state;
   // Buffer is frozen while busy, so a combinational read stays stable through WAIT.
   assign dp_instr  = busy ? mem[pc] : '0;

   always_ff @(posedge clk) begin
      if (prog_we && !busy) begin
         mem[prog_addr] <= prog_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // abort takes priority over everything, including a start in IDLE and a due capture.
   always_comb begin
      state_nxt = state;
      start_ok  = 1'b0;
      capture   = 1'b0;
      if (abort) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  start_ok  = 1'b1;
                  state_nxt = (prog_len == '0) ? DONE : ISSUE;
               end
            end
            ISSUE: begin
               state_nxt = WAIT;
            end
            WAIT: begin
               if (wait_cnt == 4'd0) begin
                  capture   = 1'b1;
                  state_nxt = end_run ? DONE : ISSUE;
               end
            end
            DONE: begin
               state_nxt = IDLE;
            end
            default: begin
               state_nxt = IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc       <= '0;
         len_r    <= '0;
         wait_cnt <= '0;
      end else begin
         if (start_ok) begin
            pc    <= '0;
            len_r <= (prog_len > LEN_MAX) ? LEN_MAX : prog_len;
         end else if (capture && !end_run) begin
            pc <= pc + AW'(1);
         end
         if (state == ISSUE) begin
            wait_cnt <= SETTLE_M1;
         end else if ((state == WAIT) && (wait_cnt != 4'd0)) begin
            wait_cnt <= wait_cnt - 4'd1;
         end
      end
   end

   // Results are a fire-and-forget pulse: res_valid is high for one cycle per capture, with no
   // ready/back-pressure; res_data/res_zf/res_idx stay put until the next capture.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res_valid <= 1'b0;
         res_data  <= '0;
         res_zf    <= 1'b0;
         res_idx   <= '0;
         zf_count  <= '0;
      end else begin
         res_valid <= capture;
         if (start_ok) begin
            zf_count <= '0;
         end else if (capture) begin
            zf_count <= zf_count + (AW+1)'(dp_zf);
         end
         if (capture) begin
            res_data <= dp_data;
            res_zf   <= dp_zf;
            res_idx  <= pc;
         end
      end
   end

`ifdef JSEQ_ZF_HALT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         halted <= 1'b0;
      end else if (start_ok) begin
         halted <= 1'b0;
      end else if (capture && halt_hit) begin
         halted <= 1'b1;
      end
   end
`endif

`ifndef SYNTHESIS
   a_busy_done_excl: assert property (@(posedge clk) disable iff (!rst_n) !(busy && done));
   a_idle_instr_zero: assert property (@(posedge clk) disable iff (!rst_n) !busy |-> (dp_instr == '0));
   a_zf_count_range: assert property (@(posedge clk) disable iff (!rst_n) zf_count <= LEN_MAX);
   a_len_range: assert property (@(posedge clk) disable iff (!rst_n) len_r <= LEN_MAX);
`endif

endmodule

// File: tb/tb_jericalla_sequencer.sv
// Directed self-checking bench for jericalla_sequencer with a stub datapath
// (data_out = {15'h0, instr} ^ 32'hFFFF_0000, zf = instr[16]).
module tb_jericalla_sequencer;

   localparam int INSTR_W = 17;
   localparam int DATA_W  = 32;
   localparam int DEPTH   = 8;
   localparam int SETTLE  = 2;
   localparam int AW      = 3;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_WAIT  = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   localparam logic [INSTR_W-1:0] I_A = 17'b00110010010001101;
   localparam logic [INSTR_W-1:0] I_B = 17'h0ABCD;
   localparam logic [INSTR_W-1:0] I_C = 17'h10F0F;
   localparam logic [DATA_W-1:0]  D_A = 32'hFFFF648D;
   localparam logic [DATA_W-1:0]  D_B = 32'hFFFFABCD;
   localparam logic [DATA_W-1:0]  D_C = 32'hFFFE0F0F;

   // ---------------- clock / reset / signals ----------------
   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic               prog_we = 1'b0;
   logic [AW-1:0]      prog_addr = '0;
   logic [INSTR_W-1:0] prog_data = '0;
   logic [AW:0]        prog_len = '0;
   logic               start = 1'b0;
   logic               abort = 1'b0;
   logic [INSTR_W-1:0] dp_instr;
   logic [DATA_W-1:0]  dp_data;
   logic               dp_zf;
   logic               res_valid;
   logic [DATA_W-1:0]  res_data;
   logic               res_zf;
   logic [AW-1:0]      res_idx;
   logic [AW:0]        zf_count;
   logic               busy;
   logic [1:0]         state_dbg;
   logic               done;
`ifdef JSEQ_ZF_HALT_EN
   logic               halted;
`endif

   always #5 clk = ~clk;

   assign dp_data = {15'h0, dp_instr} ^ 32'hFFFF_0000;
   assign dp_zf   = dp_instr[16];

   jericalla_sequencer #(
      .INSTR_W(INSTR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .SETTLE(SETTLE)
   ) dut (
      .clk(clk), .rst_n(rst_n), .prog_we(prog_we), .prog_addr(prog_addr),
      .prog_data(prog_data), .prog_len(prog_len), .start(start), .abort(abort),
      .dp_instr(dp_instr), .dp_data(dp_data), .dp_zf(dp_zf),
      .res_valid(res_valid), .res_data(res_data), .res_zf(res_zf), .res_idx(res_idx),
      .zf_count(zf_count), .busy(busy), .state_dbg(state_dbg), .done(done)
`ifdef JSEQ_ZF_HALT_EN
      , .halted(halted)
`endif
   );

   // ---------------- monitor / scoreboard storage ----------------
   int                cyc = 0;
   int                checks = 0;
   int                errors = 0;
   int                rv_cyc_q[$];
   logic [AW-1:0]     rv_idx_q[$];
   logic [DATA_W-1:0] rv_data_q[$];
   logic              rv_zf_q[$];
   int                done_q[$];
   logic [DATA_W-1:0] exp_q[$];

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (res_valid === 1'b1) begin
         rv_cyc_q.push_back(cyc);
         rv_idx_q.push_back(res_idx);
         rv_data_q.push_back(res_data);
         rv_zf_q.push_back(res_zf);
      end
      if (done === 1'b1) done_q.push_back(cyc);
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input logic [AW-1:0] a, input logic [INSTR_W-1:0] d);
      prog_we = 1'b1; prog_addr = a; prog_data = d;
      tick();
      prog_we = 1'b0;
   endtask

   // Drives start for one edge (E0); returns E0's cycle index, leaves us in the cycle after E0.
   task automatic kick(input logic [AW:0] len, output int e0);
      prog_len = len; start = 1'b1;
      e0 = cyc + 1;
      tick();
      start = 1'b0;
   endtask

   task automatic clear_mon();
      rv_cyc_q.delete(); rv_idx_q.delete(); rv_data_q.delete(); rv_zf_q.delete();
      done_q.delete(); exp_q.delete();
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      int e0;
      #2;
      checks++; if (dp_instr !== '0) begin errors++; $display("FAIL rst_dp_instr got=%h exp=0", dp_instr); end
      checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL rst_res_valid got=%b exp=0", res_valid); end
      checks++; if (res_data !== '0) begin errors++; $display("FAIL rst_res_data got=%h exp=0", res_data); end
      checks++; if ({res_zf, res_idx, zf_count} !== '0) begin errors++; $display("FAIL rst_res_misc got=%b/%0d/%0d exp=0", res_zf, res_idx, zf_count); end
      checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL rst_busy_done got=%b%b exp=00", busy, done); end
      checks++; if (state_dbg !== S_IDLE) begin errors++; $display("FAIL rst_state got=%0d exp=%0d", state_dbg, S_IDLE); end
      @(negedge clk); rst_n = 1'b1;
      tick();
      load(0, I_A); load(1, I_B); load(2, I_C);
      kick(3, e0);
      tick();
      checks++; if (state_dbg !== S_WAIT || busy !== 1'b1) begin errors++; $display("FAIL midrun_state got=%0d busy=%b exp=%0d busy=1", state_dbg, busy, S_WAIT); end
      #3; rst_n = 1'b0; #1;
      checks++; if (dp_instr !== '0) begin errors++; $display("FAIL async_rst_dp_instr got=%h exp=0", dp_instr); end
      checks++; if (busy !== 1'b0 || res_valid !== 1'b0) begin errors++; $display("FAIL async_rst_busy_rv got=%b%b exp=00", busy, res_valid); end
      checks++; if (state_dbg !== S_IDLE) begin errors++; $display("FAIL async_rst_state got=%0d exp=%0d", state_dbg, S_IDLE); end
      @(negedge clk); rst_n = 1'b1;
      clear_mon();
      repeat (6) tick();
      checks++; if (rv_cyc_q.size() != 0 || done_q.size() != 0) begin errors++; $display("FAIL post_rst_quiet got=%0d/%0d exp=0/0", rv_cyc_q.size(), done_q.size()); end
   endtask

   task automatic test_run3();
      int e0;
      int n;
      clear_mon();
      exp_q.push_back(D_A); exp_q.push_back(D_B); exp_q.push_back(D_C);
      load(0, I_A); load(1, I_B); load(2, I_C);
      kick(3, e0);
      checks++; if (state_dbg !== S_ISSUE || dp_instr !== I_A) begin errors++; $display("FAIL run3_issue got=%0d/%h exp=%0d/%h", state_dbg, dp_instr, S_ISSUE, I_A); end
      tick();
      checks++; if (dp_instr !== I_A || busy !== 1'b1) begin errors++; $display("FAIL run3_hold got=%h busy=%b exp=%h busy=1", dp_instr, busy, I_A); end
      repeat (10) tick();
      checks++; if (rv_cyc_q.size() != 3) begin errors++; $display("FAIL run3_count got=%0d exp=3", rv_cyc_q.size()); end
      n = (rv_cyc_q.size() < 3) ? rv_cyc_q.size() : 3;
      for (int i = 0; i < n; i++) begin
         checks++; if (rv_cyc_q[i] != e0 + 3 * (i + 1)) begin errors++; $display("FAIL run3_time[%0d] got=E0+%0d exp=E0+%0d", i, rv_cyc_q[i] - e0, 3 * (i + 1)); end
         checks++; if (rv_idx_q[i] !== AW'(i)) begin errors++; $display("FAIL run3_idx[%0d] got=%0d exp=%0d", i, rv_idx_q[i], i); end
         checks++; if (rv_data_q[i] !== exp_q[i]) begin errors++; $display("FAIL run3_data[%0d] got=%h exp=%h", i, rv_data_q[i], exp_q[i]); end
      end
      checks++; if (done_q.size() != 1 || (done_q.size() == 1 && done_q[0] != e0 + 9)) begin errors++; $display("FAIL run3_done got=%0d pulses exp=1 at E0+9", done_q.size()); end
      checks++; if (zf_count !== 4'd1 || res_idx !== 3'd2 || res_data !== D_C) begin errors++; $display("FAIL run3_hold_res got=%0d/%0d/%h exp=1/2/%h", zf_count, res_idx, res_data, D_C); end
      checks++; if (dp_instr !== '0 || state_dbg !== S_IDLE) begin errors++; $display("FAIL run3_idle got=%h/%0d exp=0/%0d", dp_instr, state_dbg, S_IDLE); end
   endtask

   task automatic test_len_edges();
      int e0;
      int n;
      clear_mon();
      kick(0, e0);
      checks++; if (done !== 1'b1 || state_dbg !== S_DONE || busy !== 1'b0) begin errors++; $display("FAIL len0_done got=%b/%0d/%b exp=1/%0d/0", done, state_dbg, busy, S_DONE); end
      checks++; if (zf_count !== '0) begin errors++; $display("FAIL len0_zf_clear got=%0d exp=0", zf_count); end
      repeat (4) tick();
      checks++; if (rv_cyc_q.size() != 0 || done_q.size() != 1) begin errors++; $display("FAIL len0_pulses got=rv%0d/done%0d exp=rv0/done1", rv_cyc_q.size(), done_q.size()); end
      for (int i = 0; i < DEPTH; i++) load(AW'(i), INSTR_W'(32'h100 + i));
      clear_mon();
      kick(9, e0);
      repeat (28) tick();
      checks++; if (rv_cyc_q.size() != DEPTH) begin errors++; $display("FAIL len9_count got=%0d exp=%0d", rv_cyc_q.size(), DEPTH); end
      n = (rv_cyc_q.size() < DEPTH) ? rv_cyc_q.size() : DEPTH;
      for (int i = 0; i < n; i++) begin
         checks++; if (rv_idx_q[i] !== AW'(i) || rv_data_q[i] !== (32'hFFFF0100 + 32'(i)) || rv_cyc_q[i] != e0 + 3 * (i + 1)) begin
            errors++; $display("FAIL len9_res[%0d] got=idx%0d/%h/E0+%0d exp=idx%0d/%h/E0+%0d", i, rv_idx_q[i], rv_data_q[i], rv_cyc_q[i] - e0, i, 32'hFFFF0100 + 32'(i), 3 * (i + 1));
         end
      end
      checks++; if (done_q.size() != 1 || (done_q.size() == 1 && done_q[0] != e0 + 24)) begin errors++; $display("FAIL len9_done got=%0d pulses exp=1 at E0+24", done_q.size()); end
   endtask

   task automatic test_abort();
      int e0;
      load(0, I_A); load(1, I_B); load(2, I_C);
      clear_mon();
      kick(3, e0);
      repeat (4) tick();
      checks++; if (state_dbg !== S_WAIT || dp_instr !== I_B) begin errors++; $display("FAIL abort_pre got=%0d/%h exp=%0d/%h", state_dbg, dp_instr, S_WAIT, I_B); end
      abort = 1'b1;
      tick();
      abort = 1'b0;
      checks++; if (state_dbg !== S_IDLE || busy !== 1'b0 || dp_instr !== '0) begin errors++; $display("FAIL abort_idle got=%0d/%b/%h exp=%0d/0/0", state_dbg, busy, dp_instr, S_IDLE); end
      repeat (6) tick();
      checks++; if (rv_cyc_q.size() != 1 || done_q.size() != 0) begin errors++; $display("FAIL abort_pulses got=rv%0d/done%0d exp=rv1/done0", rv_cyc_q.size(), done_q.size()); end
      checks++; if (res_idx !== 3'd0 || res_data !== D_A || zf_count !== '0) begin errors++; $display("FAIL abort_held got=%0d/%h/%0d exp=0/%h/0", res_idx, res_data, zf_count, D_A); end
      clear_mon();
      prog_len = 3; start = 1'b1; abort = 1'b1;
      tick();
      start = 1'b0; abort = 1'b0;
      checks++; if (state_dbg !== S_IDLE || busy !== 1'b0) begin errors++; $display("FAIL abort_beats_start got=%0d/%b exp=%0d/0", state_dbg, busy, S_IDLE); end
      repeat (5) tick();
      checks++; if (rv_cyc_q.size() != 0 || done_q.size() != 0) begin errors++; $display("FAIL abort_start_quiet got=rv%0d/done%0d exp=0/0", rv_cyc_q.size(), done_q.size()); end
   endtask

   task automatic test_busy_ignore();
      int e0;
      clear_mon();
      kick(3, e0);
      tick();
      prog_we = 1'b1; prog_addr = 1; prog_data = 17'h01111; start = 1'b1; prog_len = 0;
      tick();
      prog_we = 1'b0; start = 1'b0;
      repeat (9) tick();
      checks++; if (rv_cyc_q.size() != 3) begin errors++; $display("FAIL busy_count got=%0d exp=3", rv_cyc_q.size()); end
      if (rv_cyc_q.size() >= 2) begin
         checks++; if (rv_data_q[1] !== D_B || rv_cyc_q[1] != e0 + 6) begin errors++; $display("FAIL busy_res1 got=%h/E0+%0d exp=%h/E0+6", rv_data_q[1], rv_cyc_q[1] - e0, D_B); end
      end
      checks++; if (done_q.size() != 1 || (done_q.size() == 1 && done_q[0] != e0 + 9)) begin errors++; $display("FAIL busy_done got=%0d pulses exp=1 at E0+9", done_q.size()); end
      clear_mon();
      kick(2, e0);
      repeat (8) tick();
      checks++; if (rv_data_q.size() != 2 || (rv_data_q.size() == 2 && rv_data_q[1] !== D_B)) begin errors++; $display("FAIL busy_buf_kept got=%0d results exp=2 with idx1=%h", rv_data_q.size(), D_B); end
   endtask

   task automatic test_back_to_back();
      int e0;
      int e1;
      clear_mon();
      prog_we = 1'b1; prog_addr = 0; prog_data = 17'h07777;
      kick(1, e0);
      prog_we = 1'b0;
      repeat (3) tick();
      checks++; if (done !== 1'b1 || res_valid !== 1'b1 || res_data !== 32'hFFFF7777) begin errors++; $display("FAIL wr_start_same got=%b/%b/%h exp=1/1/ffff7777", done, res_valid, res_data); end
      tick();
      kick(1, e1);
      repeat (4) tick();
      checks++; if (rv_cyc_q.size() != 2) begin errors++; $display("FAIL b2b_count got=%0d exp=2", rv_cyc_q.size()); end
      if (rv_cyc_q.size() == 2) begin
         checks++; if (rv_cyc_q[0] != e0 + 3 || rv_cyc_q[1] != e1 + 3 || e1 != e0 + 5) begin errors++; $display("FAIL b2b_time got=E0+%0d/E0+%0d exp=E0+3/E0+8", rv_cyc_q[0] - e0, rv_cyc_q[1] - e0); end
         checks++; if (rv_data_q[1] !== 32'hFFFF7777) begin errors++; $display("FAIL b2b_data got=%h exp=ffff7777", rv_data_q[1]); end
      end
   endtask

   task automatic test_zf();
      int e0;
      load(0, 17'h00011); load(1, 17'h10022); load(2, 17'h00033); load(3, 17'h00044);
      clear_mon();
      kick(4, e0);
      repeat (15) tick();
`ifdef JSEQ_ZF_HALT_EN
      checks++; if (rv_cyc_q.size() != 2) begin errors++; $display("FAIL zfhalt_count got=%0d exp=2", rv_cyc_q.size()); end
      checks++; if (done_q.size() != 1 || (done_q.size() == 1 && done_q[0] != e0 + 6)) begin errors++; $display("FAIL zfhalt_done got=%0d pulses exp=1 at E0+6", done_q.size()); end
      checks++; if (halted !== 1'b1 || res_idx !== 3'd1 || zf_count !== 4'd1) begin errors++; $display("FAIL zfhalt_state got=%b/%0d/%0d exp=1/1/1", halted, res_idx, zf_count); end
`else
      checks++; if (rv_cyc_q.size() != 4) begin errors++; $display("FAIL zf_count_results got=%0d exp=4", rv_cyc_q.size()); end
      if (rv_zf_q.size() == 4) begin
         checks++; if ({rv_zf_q[0], rv_zf_q[1], rv_zf_q[2], rv_zf_q[3]} !== 4'b0100) begin errors++; $display("FAIL zf_flags got=%b%b%b%b exp=0100", rv_zf_q[0], rv_zf_q[1], rv_zf_q[2], rv_zf_q[3]); end
      end
      checks++; if (zf_count !== 4'd1) begin errors++; $display("FAIL zf_total got=%0d exp=1", zf_count); end
      checks++; if (done_q.size() != 1 || (done_q.size() == 1 && done_q[0] != e0 + 12)) begin errors++; $display("FAIL zf_done got=%0d pulses exp=1 at E0+12", done_q.size()); end
`endif
   endtask

   initial begin
      test_reset();
      test_run3();
      test_len_edges();
      test_abort();
      test_busy_ignore();
      test_back_to_back();
      test_zf();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
